bypass_scoreboard: RTL

BYPASS_SCOREBOARD -- requirements
Module: bypass_scoreboard

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/fwd_match.sv | 34 +++
 rtl/bypass_scoreboard.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode constants and writer/load decode helpers
// used by the bypass scoreboard and its operand matchers.
package pipe_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b01011;

    localparam int SEL_W = 3;

    // Opcodes that write a destination register.
    function automatic logic is_writer(input logic [4:0] op);
        logic w;
        case (op)
            OP_ALU:  w = 1'b1;
            OP_ADDI: w = 1'b1;
            OP_LW:   w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic is_load(input logic [4:0] op);
        return (op == OP_LW);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher for one source operand: finds the youngest in-flight
// producer of the register and reports whether its result is available yet.
module fwd_match
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int REG_W      = 5
) (
    input  logic                   uses,
    input  logic [REG_W-1:0]       src,
    input  logic [DEPTH-1:0]       valid,
    input  logic [DEPTH*REG_W-1:0] rd_flat,
    input  logic [DEPTH-1:0]       is_load,
    output logic [SEL_W-1:0]       sel,
    output logic                   not_ready
);

    logic [DEPTH-1:0] hit_s;

    // Scan oldest to youngest so the youngest hit overwrites older ones.
    always_comb begin
        hit_s     = '0;
        sel       = 3'd0;
        not_ready = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            hit_s[k-1] = uses && (src != '0) && valid[k-1] &&
                         (rd_flat[(k-1)*REG_W +: REG_W] == src);
            sel        = hit_s[k-1] ? SEL_W'(k) : sel;
            not_ready  = hit_s[k-1] ? (is_load[k-1] && (k < LOAD_STAGE)) : not_ready;
        end
    end

endmodule

// File: rtl/bypass_scoreboard.sv
// In-order pipeline scoreboard: tracks destination registers of in-flight
// instructions, selects bypass sources and stalls on unresolved load-use hazards.
module bypass_scoreboard
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int REG_W      = 5,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       issue_opcode,
    input  logic [REG_W-1:0] issue_rd,
    input  logic [REG_W-1:0] issue_rs,
    input  logic [REG_W-1:0] issue_rt,
    input  logic             issue_uses_rs,
    input  logic             issue_uses_rt,
    input  logic             flush,
    output logic             stall,
    output logic [2:0]       fwd_sel_a,
    output logic [2:0]       fwd_sel_b,
    output logic [CNT_W-1:0] stall_count
);

    if (DEPTH < 2 || DEPTH > 7) begin : g_bad_depth
        $error("bypass_scoreboard: DEPTH must be within 2..7");
    end
    if (LOAD_STAGE < 1 || LOAD_STAGE > DEPTH) begin : g_bad_load_stage
        $error("bypass_scoreboard: LOAD_STAGE must be within 1..DEPTH");
    end

    // Bit k-1 of each vector describes the instruction in stage k.
    logic [DEPTH-1:0]       valid_r;
    logic [DEPTH-1:0]       is_load_r;
    logic [DEPTH*REG_W-1:0] rd_r;
    logic [CNT_W-1:0]       count_r;

    logic [SEL_W-1:0] sel_a_s;
    logic [SEL_W-1:0] sel_b_s;
    logic             not_ready_a_s;
    logic             not_ready_b_s;
    logic             stall_s;
    logic             enter_s;

    fwd_match #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .REG_W(REG_W)) u_match_rs (
        .uses      (issue_uses_rs),
        .src       (issue_rs),
        .valid     (valid_r),
        .rd_flat   (rd_r),
        .is_load   (is_load_r),
        .sel       (sel_a_s),
        .not_ready (not_ready_a_s)
    );

    fwd_match #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .REG_W(REG_W)) u_match_rt (
        .uses      (issue_uses_rt),
        .src       (issue_rt),
        .valid     (valid_r),
        .rd_flat   (rd_r),
        .is_load   (is_load_r),
        .sel       (sel_b_s),
        .not_ready (not_ready_b_s)
    );

    // Hazard decision and stage-1 admission; reset and flush suppress both.
    always_comb begin
        stall_s = 1'b0;
        enter_s = 1'b0;
        if (!reset && issue_valid && !flush) begin
            stall_s = not_ready_a_s || not_ready_b_s;
            enter_s = !stall_s && is_writer(issue_opcode) && (issue_rd != '0);
        end else begin
            stall_s = 1'b0;
            enter_s = 1'b0;
        end
    end

    // Outputs are forced quiet while reset is held.
    always_comb begin
        stall     = stall_s;
        fwd_sel_a = 3'd0;
        fwd_sel_b = 3'd0;
        if (reset) begin
            fwd_sel_a = 3'd0;
            fwd_sel_b = 3'd0;
        end else begin
            fwd_sel_a = sel_a_s;
            fwd_sel_b = sel_b_s;
        end
    end

    // Entry shift register; the oldest entry falls off as it retires.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r   <= '0;
            is_load_r <= '0;
            rd_r      <= '0;
        end else if (flush) begin
            valid_r   <= '0;
            is_load_r <= '0;
            rd_r      <= '0;
        end else begin
            valid_r   <= {valid_r[DEPTH-2:0], enter_s};
            is_load_r <= {is_load_r[DEPTH-2:0], enter_s && is_load(issue_opcode)};
            rd_r      <= {rd_r[(DEPTH-1)*REG_W-1:0], issue_rd};
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (stall_s && (count_r != '1)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign stall_count = count_r;

endmodule
